// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: byte-lane ordering, store-size encodings and the
// data-memory controller states.
package riscv_pkg;

    localparam logic RISCV_LITTLE_ENDIAN = 1'b0;
    localparam logic RISCV_BIG_ENDIAN    = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/riscv_dmem_lane.sv
// Store steering: turns size, address low bits and endianness into a byte-lane
// mask, a lane-replicated data word and a misalignment/reserved-size error.
module riscv_dmem_lane
    import riscv_pkg::*;
#(
    parameter logic MP_ENDIANESS = RISCV_BIG_ENDIAN
) (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  mask,
    output logic [31:0] steered,
    output logic        err
);

    logic [1:0] byte_lane;
    logic       half_hi;

    // Big-endian puts byte 0 in the top lane, so the lane index is mirrored.
    assign byte_lane = (MP_ENDIANESS == RISCV_BIG_ENDIAN) ? ~addr_lo : addr_lo;
    assign half_hi   = (MP_ENDIANESS == RISCV_BIG_ENDIAN) ? ~addr_lo[1] : addr_lo[1];

    always_comb begin
        mask    = 4'b0000;
        steered = data;
        err     = 1'b0;
        case (size)
            SZ_BYTE: begin
                steered = {4{data[7:0]}};
                mask    = 4'b0001 << byte_lane;
            end
            SZ_HALF: begin
                steered = {2{data[15:0]}};
                if (addr_lo[0]) err = 1'b1;
                else            mask = half_hi ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (addr_lo != 2'b00) err = 1'b1;
                else                  mask = 4'b1111;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_dmem.sv
// Data memory with byte-lane stores, a preload port and a sticky store-error
// flag. Define RISCV_DMEM_CLEAR_EN to zero the array after every reset.
module riscv_dmem
    import riscv_pkg::*;
#(
    parameter int   MP_DATA_WIDTH = 32,
    parameter int   MP_DEPTH_LOG2 = 10,
    parameter logic MP_ENDIANESS  = RISCV_BIG_ENDIAN
) (
    input  logic                     iclk,
    input  logic                     irstn,
    input  logic [31:0]              idmem_addr,
    input  logic [1:0]               idmem_wr_be,
    input  logic                     idmem_wr_en,
    input  logic [MP_DATA_WIDTH-1:0] idmem_wr_data,
    output logic [MP_DATA_WIDTH-1:0] odmem_rd_data,
    input  logic                     iload_valid,
    output logic                     oload_ready,
    input  logic [MP_DEPTH_LOG2-1:0] iload_addr,
    input  logic [MP_DATA_WIDTH-1:0] iload_data,
    output logic                     oready,
    output logic                     oerr,
    input  logic                     ierr_clr
);

    localparam int LP_WORDS = 1 << MP_DEPTH_LOG2;

    logic [MP_DATA_WIDTH-1:0] mem [LP_WORDS];

    dmem_state_e              state, state_nxt;
    logic [MP_DEPTH_LOG2-1:0] word_idx;
    logic [3:0]               lane_mask;
    logic [31:0]              lane_data;
    logic                     lane_err;
    logic                     store_ok, store_bad;
    logic                     clear_wr, clear_done;
    logic                     unused_addr_hi;

    assign word_idx       = idmem_addr[MP_DEPTH_LOG2+1:2];
    assign unused_addr_hi = &{1'b0, idmem_addr[31:MP_DEPTH_LOG2+2]};

    riscv_dmem_lane #(.MP_ENDIANESS(MP_ENDIANESS)) u_lane (
        .size    (idmem_wr_be),
        .addr_lo (idmem_addr[1:0]),
        .data    (idmem_wr_data),
        .mask    (lane_mask),
        .steered (lane_data),
        .err     (lane_err)
    );

    assign oready        = (state == ST_READY);
    assign store_ok      = oready && idmem_wr_en && !lane_err;
    assign store_bad     = oready && idmem_wr_en && lane_err;
    assign oload_ready   = oready && iload_valid && !idmem_wr_en;
    assign odmem_rd_data = oready ? mem[word_idx] : '0;

`ifdef RISCV_DMEM_CLEAR_EN
    // One extra count past the last word so READY follows the final clear write.
    localparam logic [MP_DEPTH_LOG2:0] LP_CLR_END = (MP_DEPTH_LOG2+1)'(LP_WORDS);
    logic [MP_DEPTH_LOG2:0] clr_idx;

    assign clear_done = (clr_idx == LP_CLR_END);
    assign clear_wr   = (state == ST_CLEAR) && !clear_done;

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn)        clr_idx <= '0;
        else if (clear_wr) clr_idx <= clr_idx + 1'b1;
    end
`else
    // Without the sweep, CLEAR lasts exactly one edge and writes nothing.
    assign clear_done = 1'b1;
    assign clear_wr   = 1'b0;
`endif

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clear_done) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn)         oerr <= 1'b0;
        else if (store_bad) oerr <= 1'b1;
        else if (ierr_clr)  oerr <= 1'b0;
    end

    // Loader and core stores are mutually exclusive through oload_ready.
    always_ff @(posedge iclk) begin
`ifdef RISCV_DMEM_CLEAR_EN
        if (irstn && clear_wr) mem[clr_idx[MP_DEPTH_LOG2-1:0]] <= '0;
`endif
        if (oload_ready) mem[iload_addr] <= iload_data;
        if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem.sv
// Scoreboard bench: one big-endian and one little-endian instance share the
// stimulus; expectations are queued and checked by a negedge monitor.
module tb_riscv_dmem;
    import riscv_pkg::*;

`ifdef RISCV_DMEM_CLEAR_EN
    localparam int DEPTH       = 4;
    localparam int READY_EDGES = 17;
`else
    localparam int DEPTH       = 10;
    localparam int READY_EDGES = 1;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [31:0]       addr;
    logic [1:0]        wr_be;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              load_valid;
    logic [DEPTH-1:0]  load_addr;
    logic [31:0]       load_data;
    logic              err_clr;

    logic [31:0] rd_be, rd_le;
    logic        lr_be, lr_le, rdy_be, rdy_le, err_be, err_le;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    riscv_dmem #(.MP_DATA_WIDTH(32), .MP_DEPTH_LOG2(DEPTH), .MP_ENDIANESS(RISCV_BIG_ENDIAN)) dut_be (
        .iclk(clk), .irstn(rstn), .idmem_addr(addr), .idmem_wr_be(wr_be), .idmem_wr_en(wr_en),
        .idmem_wr_data(wr_data), .odmem_rd_data(rd_be), .iload_valid(load_valid), .oload_ready(lr_be),
        .iload_addr(load_addr), .iload_data(load_data), .oready(rdy_be), .oerr(err_be), .ierr_clr(err_clr)
    );

    riscv_dmem #(.MP_DATA_WIDTH(32), .MP_DEPTH_LOG2(DEPTH), .MP_ENDIANESS(RISCV_LITTLE_ENDIAN)) dut_le (
        .iclk(clk), .irstn(rstn), .idmem_addr(addr), .idmem_wr_be(wr_be), .idmem_wr_en(wr_en),
        .idmem_wr_data(wr_data), .odmem_rd_data(rd_le), .iload_valid(load_valid), .oload_ready(lr_le),
        .iload_addr(load_addr), .iload_data(load_data), .oready(rdy_le), .oerr(err_le), .ierr_clr(err_clr)
    );

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:       return rd_be;
            1:       return rd_le;
            2:       return {31'd0, err_be};
            3:       return {31'd0, err_le};
            4:       return {31'd0, lr_be};
            5:       return {31'd0, lr_le};
            6:       return {31'd0, rdy_be};
            default: return {31'd0, rdy_le};
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s[%0d]", e.name, e.sel), observe(e.sel), e.exp);
        end
    end

    task automatic push(string n, int sel, logic [31:0] v);
        exp_t e;
        e.name = n; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_rd(string n, logic [31:0] be, logic [31:0] le);
        push(n, 0, be);
        push(n, 1, le);
    endtask

    task automatic exp_both(string n, int sel_be, logic [31:0] v);
        push(n, sel_be, v);
        push(n, sel_be + 1, v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        addr = a; wr_be = sz; wr_data = d; wr_en = 1'b1;
    endtask

    task automatic wait_ready(string n);
        int edges = 0;
        while (rdy_be !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
        check(n, edges, READY_EDGES);
        push(n, 7, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; addr = '0; wr_be = SZ_WORD; wr_en = 1'b0; wr_data = '0;
        load_valid = 1'b1; load_addr = '0; load_data = 32'hFFFF_FFFF; err_clr = 1'b0;
        #2;
        exp_both("rst_ready", 6, 0);
        exp_both("rst_err", 2, 0);
        exp_both("rst_load_ready", 4, 0);
        exp_rd("rst_rd", 32'h0, 32'h0);
        tick(); tick();
        load_valid = 1'b0;
        rstn = 1'b1;
        wait_ready("ready_edges");

`ifdef RISCV_DMEM_CLEAR_EN
        for (int w = 0; w < 4; w++) begin
            addr = 32'(w * 4);
            exp_rd("cleared", 32'h0, 32'h0);
            tick();
        end
        rstn = 1'b0; tick(); rstn = 1'b1;
        repeat (8) tick();
        exp_both("mid_clear_not_ready", 6, 0);
        tick();
        rstn = 1'b0; tick(); rstn = 1'b1;
        wait_ready("restart_edges");
`endif

        load_valid = 1'b1; load_addr = DEPTH'(1); load_data = 32'h1122_3344;
        exp_both("load_ready", 4, 1);
        tick();
        load_valid = 1'b0; addr = 32'h4;
        exp_rd("preload_w1", 32'h1122_3344, 32'h1122_3344);
        tick();

        store(32'h5, SZ_BYTE, 32'h0000_00AB);
        exp_rd("read_before_write", 32'h1122_3344, 32'h1122_3344);
        tick();
        wr_en = 1'b0; addr = 32'h4;
        exp_rd("byte_store", 32'h11AB_3344, 32'h1122_AB44);
        exp_both("err_after_byte", 2, 0);
        tick();

        load_valid = 1'b1; load_addr = '0; load_data = 32'h0;
        tick();
        load_valid = 1'b0;
        store(32'h2, SZ_HALF, 32'h0000_BEEF);
        tick();
        wr_en = 1'b0; addr = 32'h0;
        exp_rd("half_store", 32'h0000_BEEF, 32'hBEEF_0000);
        tick();
        store(32'h3, SZ_HALF, 32'h0000_1234);
        tick();
        wr_en = 1'b0; addr = 32'h0;
        exp_rd("half_misaligned_nowrite", 32'h0000_BEEF, 32'hBEEF_0000);
        exp_both("err_half_misaligned", 2, 1);
        tick();

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_both("err_clr", 2, 0);
        tick();

        store(32'h0, SZ_RSVD, 32'hFFFF_FFFF);
        tick();
        wr_en = 1'b0;
        exp_rd("rsvd_nowrite", 32'h0000_BEEF, 32'hBEEF_0000);
        exp_both("err_rsvd", 2, 1);
        tick();

        store(32'h6, SZ_WORD, 32'hFFFF_FFFF);
        err_clr = 1'b1;
        tick();
        wr_en = 1'b0; err_clr = 1'b0; addr = 32'h4;
        exp_both("clr_vs_new_err", 2, 1);
        exp_rd("word_misaligned_nowrite", 32'h11AB_3344, 32'h1122_AB44);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_both("err_clr2", 2, 0);
        tick();

        load_valid = 1'b1; load_addr = DEPTH'(3); load_data = 32'hDEAD_BEEF;
        store(32'h8, SZ_WORD, 32'hCAFE_F00D);
        exp_both("load_blocked", 4, 0);
        tick();
        wr_en = 1'b0;
        exp_both("load_retry", 4, 1);
        tick();
        load_valid = 1'b0; addr = 32'hC;
        exp_rd("load_word3", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        addr = 32'h8;
        exp_rd("store_word2", 32'hCAFE_F00D, 32'hCAFE_F00D);
        tick();

        store(32'h0000_1004, SZ_WORD, 32'h1234_5678);
        tick();
        wr_en = 1'b0; addr = 32'h4;
        exp_rd("alias_store", 32'h1234_5678, 32'h1234_5678);
        tick();
        addr = 32'h0000_1004;
        exp_rd("alias_read", 32'h1234_5678, 32'h1234_5678);
        tick();

        store(32'hB, SZ_BYTE, 32'h0000_005A);
        tick();
        wr_en = 1'b0; addr = 32'h8;
        exp_rd("byte_lane3", 32'hCAFE_F05A, 32'h5AFE_F00D);
        tick();

        store(32'h1, SZ_WORD, 32'h0);
        tick();
        wr_en = 1'b0;
        exp_both("err_before_reset", 2, 1);
        tick();
        rstn = 1'b0; addr = 32'hC; load_valid = 1'b1;
        exp_both("reset_ready", 6, 0);
        exp_both("reset_err", 2, 0);
        exp_both("reset_load_ready", 4, 0);
        exp_rd("reset_rd", 32'h0, 32'h0);
        tick();
        rstn = 1'b1; load_valid = 1'b0;
        wait_ready("ready_edges2");
`ifdef RISCV_DMEM_CLEAR_EN
        exp_rd("contents_after_reset", 32'h0, 32'h0);
`else
        exp_rd("contents_after_reset", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
`endif
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
